// File: rtl/ifetch_pipe_pkg.sv
// ifetch_pipe_pkg: shared FSM state, queue-entry layout and default width for the fetch pipe
package ifetch_pipe_pkg;
  localparam int DEFAULT_WORD = 32;
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;
  typedef struct packed {
    logic [DEFAULT_WORD-1:0] pc;
    logic [DEFAULT_WORD-1:0] instr;
  } entry_t;
endpackage

// File: rtl/ifetch_pipe_fifo.sv
// fetch_fifo: flushable circular queue of DEPTH (power of two) entries, W bits wide
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [W-1:0]            wdata_i,
  output logic [W-1:0]            rdata_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_push = push_i & !flush_i & (!full_o | pop_i);
  assign do_pop = pop_i & !flush_i & !empty_o;
  always_comb begin
    rd_d = flush_i ? '0 : rd_q + AW'(do_pop);
    wr_d = flush_i ? '0 : wr_q + AW'(do_push);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/ifetch_pipe.sv
// ifetch_pipe: PC generator feeding a flushable fetch queue with redirect/halt control.
// Define IFETCH_PERF_EN to add the perf_delivered / perf_redirects counters.
module ifetch_pipe
  import ifetch_pipe_pkg::*;
#(
  parameter int WORD = DEFAULT_WORD,
  parameter int STEP = 1,
  parameter int DEPTH = 4,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  input  logic            halt,
  output logic            imem_en,
  output logic [WORD-1:0] imem_addr,
  input  logic [WORD-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_instr,
  output logic [WORD-1:0] out_pc,
  output logic [WORD-1:0] out_npc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_delivered,
  output logic [31:0]     perf_redirects
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d, infl_pc_q;
  logic infl_q;
  logic [CW-1:0] count;
  logic full, empty, push, pop;
  logic [2*WORD-1:0] head;
  // The in-flight slot is reserved in the occupancy check so a response always has room.
  assign imem_en = reset & (state_q == ST_RUN) & !redirect & ((count + CW'(infl_q)) < CW'(DEPTH));
  assign imem_addr = pc_q;
  assign push = infl_q & !redirect & !full;
  assign pop = out_valid & out_ready & !redirect;
  always_comb begin
    state_d = redirect ? ST_RUN : halt ? ST_HALT : state_q;
    pc_d = redirect ? redirect_pc : imem_en ? pc_q + WORD'(STEP) : pc_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q <= RESET_PC;
      infl_q <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      infl_q <= imem_en;
      infl_pc_q <= pc_q;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(2*WORD)) u_fifo (
    .clk(clk),
    .rst_n(reset),
    .push_i(push),
    .pop_i(pop),
    .flush_i(redirect),
    .wdata_i({infl_pc_q, imem_rdata}),
    .rdata_o(head),
    .count_o(count),
    .full_o(full),
    .empty_o(empty)
  );
  assign out_valid = !empty;
  assign out_pc = head[2*WORD-1:WORD];
  assign out_instr = head[WORD-1:0];
  assign out_npc = out_pc + WORD'(STEP);
`ifdef IFETCH_PERF_EN
  logic [31:0] deliv_q, redir_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deliv_q <= '0;
      redir_q <= '0;
    end else begin
      deliv_q <= deliv_q + 32'(pop);
      redir_q <= redir_q + 32'(redirect);
    end
  end
  assign perf_delivered = deliv_q;
  assign perf_redirects = redir_q;
`endif
endmodule

// File: tb/tb_ifetch_pipe.sv
// tb_ifetch_pipe: directed vector table plus hand sequences for stall, halt, redirect and PC wrap
module tb_ifetch_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic halt = 1'b0;
  logic imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEADBEEF;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_npc;
  int checks = 0;
  int errors = 0;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_delivered, perf_redirects;
  int sb_del = 0;
  int sb_red = 0;
`endif

  ifetch_pipe dut (
    .clk(clk),
    .reset(reset),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_npc(out_npc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_delivered(perf_delivered),
    .perf_redirects(perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, instr = addr + 0x100.
  always @(posedge clk) imem_rdata <= imem_en ? imem_addr + 32'h100 : 32'hDEADBEEF;

`ifdef IFETCH_PERF_EN
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_del <= 0;
      sb_red <= 0;
    end else begin
      if (out_valid & out_ready & !redirect) sb_del <= sb_del + 1;
      if (redirect) sb_red <= sb_red + 1;
    end
  end
`endif

  typedef struct {
    logic rd;
    logic [31:0] rpc;
    logic h;
    logic rdy;
    logic en;
    logic [31:0] addr;
    logic v;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [31:0] rpc, input logic h, input logic rdy);
    @(negedge clk);
    redirect = rd;
    redirect_pc = rpc;
    halt = h;
    out_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_en", 32'(imem_en), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int issues, delivered;
    logic [31:0] exp_pc;
    tbl[0]  = '{0, 32'h0,  0, 1, 1, 32'h0,  0, 32'h0};
    tbl[1]  = '{0, 32'h0,  0, 1, 1, 32'h1,  0, 32'h0};
    tbl[2]  = '{0, 32'h0,  0, 1, 1, 32'h2,  1, 32'h0};
    tbl[3]  = '{0, 32'h0,  0, 1, 1, 32'h3,  1, 32'h1};
    tbl[4]  = '{0, 32'h0,  0, 0, 1, 32'h4,  1, 32'h2};
    tbl[5]  = '{0, 32'h0,  0, 0, 1, 32'h5,  1, 32'h2};
    tbl[6]  = '{0, 32'h0,  0, 0, 0, 32'h6,  1, 32'h2};
    tbl[7]  = '{0, 32'h0,  0, 0, 0, 32'h6,  1, 32'h2};
    tbl[8]  = '{0, 32'h0,  0, 0, 0, 32'h6,  1, 32'h2};
    tbl[9]  = '{0, 32'h0,  0, 1, 0, 32'h6,  1, 32'h2};
    tbl[10] = '{0, 32'h0,  0, 1, 1, 32'h6,  1, 32'h3};
    tbl[11] = '{0, 32'h0,  0, 1, 1, 32'h7,  1, 32'h4};
    tbl[12] = '{0, 32'h0,  0, 0, 1, 32'h8,  1, 32'h5};
    tbl[13] = '{1, 32'h40, 0, 1, 0, 32'h9,  1, 32'h5};
    tbl[14] = '{0, 32'h0,  0, 1, 1, 32'h40, 0, 32'h0};
    tbl[15] = '{0, 32'h0,  0, 1, 1, 32'h41, 0, 32'h0};
    tbl[16] = '{0, 32'h0,  0, 1, 1, 32'h42, 1, 32'h40};
    tbl[17] = '{0, 32'h0,  0, 1, 1, 32'h43, 1, 32'h41};
    tbl[18] = '{1, 32'h80, 0, 1, 0, 32'h44, 1, 32'h42};
    tbl[19] = '{1, 32'h90, 0, 1, 0, 32'h80, 0, 32'h0};
    tbl[20] = '{0, 32'h0,  0, 1, 1, 32'h90, 0, 32'h0};
    tbl[21] = '{0, 32'h0,  0, 1, 1, 32'h91, 0, 32'h0};
    tbl[22] = '{0, 32'h0,  0, 1, 1, 32'h92, 1, 32'h90};

    do_reset();
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rd, tbl[i].rpc, tbl[i].h, tbl[i].rdy);
      chk($sformatf("v%0d_en", i), 32'(imem_en), 32'(tbl[i].en));
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("v%0d_pc", i), out_pc, tbl[i].pc);
        chk($sformatf("v%0d_instr", i), out_instr, tbl[i].pc + 32'h100);
        chk($sformatf("v%0d_npc", i), out_npc, tbl[i].pc + 32'h1);
      end
    end

    // Decode stalled from reset: four issues fill the queue, then issue resumes after a pop.
    do_reset();
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      if (imem_en) issues++;
    end
    chk("stall_issues", 32'(issues), 32'd4);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_pc", out_pc, 32'd0);
    drive(0, 0, 0, 1);
    chk("release_en", 32'(imem_en), 32'd0);
    drive(0, 0, 0, 1);
    chk("resume_en", 32'(imem_en), 32'd1);
    chk("resume_addr", imem_addr, 32'd4);
    chk("resume_pc", out_pc, 32'd1);

    // Halt with two queued and one outstanding: exactly three delivered, then idle.
    do_reset();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk("halt_last_en", 32'(imem_en), 32'd1);
    chk("halt_last_addr", imem_addr, 32'd2);
    delivered = 0;
    exp_pc = 32'd0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1);
      chk("halt_en", 32'(imem_en), 32'd0);
      if (out_valid) begin
        chk("halt_pc", out_pc, exp_pc);
        exp_pc++;
        delivered++;
      end
    end
    chk("halt_delivered", 32'(delivered), 32'd3);
    chk("halt_idle_valid", 32'(out_valid), 32'd0);
    drive(1, 32'h10, 0, 1);
    drive(0, 0, 0, 1);
    chk("restart_en", 32'(imem_en), 32'd1);
    chk("restart_addr", imem_addr, 32'h10);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("restart_valid", 32'(out_valid), 32'd1);
    chk("restart_pc", out_pc, 32'h10);

    // PC wrap at the top of the address space.
    drive(1, 32'hFFFFFFFF, 0, 1);
    drive(0, 0, 0, 1);
    chk("wrap_addr_hi", imem_addr, 32'hFFFFFFFF);
    drive(0, 0, 0, 1);
    chk("wrap_addr_lo", imem_addr, 32'h0);
    drive(0, 0, 0, 1);
    chk("wrap_valid", 32'(out_valid), 32'd1);
    chk("wrap_pc", out_pc, 32'hFFFFFFFF);
    chk("wrap_instr", out_instr, 32'hFF);
    chk("wrap_npc", out_npc, 32'h0);

`ifdef IFETCH_PERF_EN
    drive(0, 0, 0, 1);
    chk("perf_delivered", perf_delivered, 32'(sb_del));
    chk("perf_redirects", perf_redirects, 32'(sb_red));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
